// File: rtl/serial_lane_arbiter_pkg.sv
// Shared types and helpers for the serial lane arbiter.
package serial_lane_arbiter_pkg;

    // Arbiter FSM: wait for a requester, then collect one whole word from it.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Bits needed to index n lanes (never less than one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo n.
module rr_pick
    import serial_lane_arbiter_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0]        req,
    input  logic [idx_w(n)-1:0] ptr,
    output logic [idx_w(n)-1:0] gnt_idx,
    output logic                any_req
);

    localparam int W = idx_w(n);

    logic         found;
    logic [W-1:0] cand;

    // Scan lanes starting from the pointer; the first hit wins.
    always_comb begin
        gnt_idx = '0;
        any_req = |req;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < n; i++) begin
            cand = W'((int'(ptr) + i) % n);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/serial_lane_arbiter.sv
// Serial lane arbiter: grants one serial lane at a time for one whole word,
// deserializes it LSB first and emits it with its lane index, then moves the
// round-robin pointer past the served lane.
// Optional stall abort is enabled by defining ARB_TIMEOUT_EN.
module serial_lane_arbiter
    import serial_lane_arbiter_pkg::*;
#(
    parameter int n_lanes        = 4,
    parameter int width          = 8,
    parameter int timeout_cycles = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_lanes-1:0]        serial_valid,
    input  logic [n_lanes-1:0]        serial_data,
    output logic [n_lanes-1:0]        serial_ready,
    output logic                      parallel_valid,
    output logic [width-1:0]          parallel_data,
    output logic [idx_w(n_lanes)-1:0] parallel_lane,
    output logic                      timeout_err
);

    localparam int LW = idx_w(n_lanes);
    localparam int CW = $clog2(width + 1);

    state_t             state_q, state_d;
    logic [LW-1:0]      grant_q, grant_d;
    logic [LW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [width-1:0]   shift_q, shift_d;
    logic [n_lanes-1:0] ready_q, ready_d;
    logic               pvalid_q, pvalid_d;
    logic [width-1:0]   pdata_q, pdata_d;
    logic [LW-1:0]      plane_q, plane_d;

    logic [LW-1:0]      pick_idx;
    logic               any_req;
    logic               accept;
    logic [LW-1:0]      next_ptr;
    logic [width-1:0]   word;

`ifdef ARB_TIMEOUT_EN
    localparam int SW = $clog2(timeout_cycles + 1);
    logic [SW-1:0]      stall_q, stall_d;
    logic               terr_q, terr_d;
`else
    localparam int unused_timeout_cycles = timeout_cycles;
`endif

    rr_pick #(
        .n (n_lanes)
    ) u_pick (
        .req     (serial_valid),
        .ptr     (rr_q),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    // Next-state logic for arbitration, bit collection and word/abort strobes.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        ready_d  = ready_q;
        pvalid_d = 1'b0;
        pdata_d  = pdata_q;
        plane_d  = plane_q;
`ifdef ARB_TIMEOUT_EN
        stall_d  = stall_q;
        terr_d   = 1'b0;
`endif
        accept   = serial_valid[grant_q] & ready_q[grant_q];
        next_ptr = (grant_q == LW'(n_lanes - 1)) ? '0 : grant_q + LW'(1);
        word     = {serial_data[grant_q], shift_q[width-1:1]};

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d           = COLLECT;
                    grant_d           = pick_idx;
                    cnt_d             = '0;
                    ready_d           = '0;
                    ready_d[pick_idx] = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    stall_d           = '0;
`endif
                end
            end
            COLLECT: begin
                if (accept) begin
`ifdef ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (cnt_q == CW'(width - 1)) begin
                        // Last bit: publish the word and hand the datapath back.
                        pvalid_d = 1'b1;
                        pdata_d  = word;
                        plane_d  = grant_q;
                        cnt_d    = '0;
                        shift_d  = '0;
                        rr_d     = next_ptr;
                        ready_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        shift_d = word;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    // The granted lane is silent; abort the partial word once it
                    // has stalled for the full limit.
                    if (stall_q == SW'(timeout_cycles - 1)) begin
                        terr_d  = 1'b1;
                        plane_d = grant_q;
                        cnt_d   = '0;
                        shift_d = '0;
                        stall_d = '0;
                        rr_d    = next_ptr;
                        ready_d = '0;
                        state_d = IDLE;
                    end else begin
                        stall_d = stall_q + SW'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = '0;
            end
        endcase
    end

    // State and output registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            ready_q  <= '0;
            pvalid_q <= 1'b0;
            pdata_q  <= '0;
            plane_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            stall_q  <= '0;
            terr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ready_q  <= ready_d;
            pvalid_q <= pvalid_d;
            pdata_q  <= pdata_d;
            plane_q  <= plane_d;
`ifdef ARB_TIMEOUT_EN
            stall_q  <= stall_d;
            terr_q   <= terr_d;
`endif
        end
    end

    assign serial_ready   = ready_q;
    assign parallel_valid = pvalid_q;
    assign parallel_data  = pdata_q;
    assign parallel_lane  = plane_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_err    = terr_q;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Scoreboard bench for serial_lane_arbiter (4 lanes, 8-bit words).
module tb_serial_lane_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] serial_valid;
    logic [3:0] serial_data;
    logic [3:0] serial_ready;
    logic       parallel_valid;
    logic [7:0] parallel_data;
    logic [1:0] parallel_lane;
    logic       timeout_err;

    serial_lane_arbiter #(
        .n_lanes        (4),
        .width          (8),
        .timeout_cycles (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .serial_ready   (serial_ready),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_lane  (parallel_lane),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_to;
        int lane;
        int data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Per-lane source model: a bit queue, handshake tracking and a programmable pause.
    bit lane_q[4][$];
    bit acc[4];
    int acc_cnt[4];
    int pause_at[4];
    int pause_left[4];
    int last_acc_cyc[4];
    int word_cyc[$];
    int to_cyc[$];

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, req, req);
        end
    endfunction

    task automatic clear_sources();
        for (int i = 0; i < 4; i++) begin
            lane_q[i].delete();
            acc[i]        = 1'b0;
            acc_cnt[i]    = 0;
            pause_at[i]   = -1;
            pause_left[i] = 0;
        end
        sb.delete();
        word_cyc.delete();
        to_cyc.delete();
    endtask

    // Drives every lane on the falling edge; a handshake seen then completes at the next rise.
    task automatic driver();
        bit v;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && lane_q[i].size() > 0) begin
                    void'(lane_q[i].pop_front());
                    acc_cnt[i]++;
                    last_acc_cyc[i] = cyc;
                end
            end
            for (int i = 0; i < 4; i++) begin
                v = (lane_q[i].size() > 0);
                if (v && pause_left[i] > 0 && acc_cnt[i] == pause_at[i]) begin
                    v = 1'b0;
                    pause_left[i]--;
                end
                serial_valid[i] = v;
                serial_data[i]  = v ? lane_q[i][0] : 1'b0;
                acc[i]          = v && serial_ready[i] && rst;
            end
        end
    endtask

    task automatic push_word(input int lane, input logic [7:0] w);
        for (int b = 0; b < 8; b++) lane_q[lane].push_back(w[b]);
    endtask

    task automatic expect_word(input int lane, input int data);
        exp_t e;
        e.is_to = 1'b0;
        e.lane  = lane;
        e.data  = data;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        clear_sources();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int k = 0;
        while (sb.size() > 0 && k < maxc) begin
            @(posedge clk);
            k++;
        end
        check({name, "_drain"}, sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a word or an abort.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("ready_onehot0", int'($onehot0(serial_ready)), 1);
            if (parallel_valid) begin
                word_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("word lane=%0d data=0x%02h at cycle %0d", parallel_lane, parallel_data, cyc);
                    check("word_kind", 0, int'(e.is_to));
                    check("word_lane", int'(parallel_lane), e.lane);
                    check("word_data", int'(parallel_data), e.data);
                end
            end
            if (timeout_err) begin
                to_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_timeout", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("timeout lane=%0d at cycle %0d", parallel_lane, cyc);
                    check("timeout_kind", 1, int'(e.is_to));
                    check("timeout_lane", int'(parallel_lane), e.lane);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int   cnt_a;
        int   cnt_b;
        int   k;
        int   bits1[8];
        exp_t e;

        serial_valid = '0;
        serial_data  = '0;
        clear_sources();
        fork
            driver();
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(serial_ready), 0);
        check("rst_pvalid", int'(parallel_valid), 0);
        check("rst_pdata", int'(parallel_data), 0);
        check("rst_plane", int'(parallel_lane), 0);
        check("rst_terr", int'(timeout_err), 0);
        rst = 1'b1;

        // Single lane 2, bits 1,0,1,1,0,0,1,0 LSB first -> 0x4D.
        @(posedge clk);
        #1;
        bits1 = '{1, 0, 1, 1, 0, 0, 1, 0};
        expect_word(2, 'h4D);
        for (int b = 0; b < 8; b++) lane_q[2].push_back(bits1[b] != 0);
        cnt_a = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (serial_ready == 4'b0100) cnt_a++;
        end
        check("t1_ready_cycles", cnt_a, 8);
        check("t1_words", word_cyc.size(), 1);
        wait_drain("t1", 10);

        // Lanes 0 and 3 continuously: (0,FF), (3,00), (0,FF), 9 cycles apart.
        do_reset();
        expect_word(0, 'hFF);
        expect_word(3, 'h00);
        expect_word(0, 'hFF);
        push_word(0, 8'hFF);
        push_word(0, 8'hFF);
        push_word(3, 8'h00);
        wait_drain("t2", 60);
        check("t2_words", word_cyc.size(), 3);
        if (word_cyc.size() >= 3) begin
            check("t2_gap01", word_cyc[1] - word_cyc[0], 9);
            check("t2_gap12", word_cyc[2] - word_cyc[1], 9);
        end

        // Lane 1 stalls 5 cycles after bit 3; lane 0 waits behind it.
        do_reset();
        pause_at[1]   = 3;
        pause_left[1] = 5;
        expect_word(1, 'hA5);
        expect_word(0, 'h3C);
        push_word(1, 8'hA5);
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (serial_ready == 4'b0010) cnt_a++;
            if (serial_ready == 4'b0001) cnt_b++;
            if (c == 2) begin
                #1 push_word(0, 8'h3C);
            end
        end
        check("t3_lane1_ready_cycles", cnt_a, 13);
        check("t3_lane0_ready_cycles", cnt_b, 8);
        wait_drain("t3", 10);

        // Asynchronous reset halfway through a lane 2 word.
        do_reset();
        expect_word(1, 'h5A);
        push_word(1, 8'h5A);
        wait_drain("t4a", 30);
        push_word(2, 8'hC3);
        k = 0;
        while (acc_cnt[2] < 4 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t4_bits_before_reset", int'(acc_cnt[2] >= 4), 1);
        #1 rst = 1'b0;
        #1;
        check("t4_ready", int'(serial_ready), 0);
        check("t4_pvalid", int'(parallel_valid), 0);
        check("t4_pdata", int'(parallel_data), 0);
        check("t4_plane", int'(parallel_lane), 0);
        clear_sources();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        expect_word(0, 'h11);
        expect_word(2, 'h22);
        push_word(0, 8'h11);
        push_word(2, 8'h22);
        wait_drain("t4b", 40);

        // Pointer wraps from lane 3 back to lane 0.
        do_reset();
        expect_word(3, 'h81);
        push_word(3, 8'h81);
        wait_drain("t5a", 30);
        expect_word(0, 'h0F);
        expect_word(3, 'hF0);
        push_word(0, 8'h0F);
        push_word(3, 8'hF0);
        wait_drain("t5b", 40);

`ifdef ARB_TIMEOUT_EN
        // Lane 1 goes silent after bit 2: abort after 16 idle cycles, then lane 2.
        do_reset();
        pause_at[1]   = 2;
        pause_left[1] = 1000;
        e.is_to = 1'b1;
        e.lane  = 1;
        e.data  = 0;
        sb.push_back(e);
        expect_word(2, 'h66);
        push_word(1, 8'hFF);
        push_word(2, 8'h66);
        wait_drain("t6", 80);
        check("t6_timeouts", to_cyc.size(), 1);
        if (to_cyc.size() >= 1) check("t6_timeout_delay", to_cyc[0] - last_acc_cyc[1], 16);
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_lane_arbiter.md
Name: serial_lane_arbiter

Overview:
- Shares one serial-to-parallel deserializing datapath between n_lanes independent one-bit serial sources.
- Grants one lane at a time for exactly one whole word of width bits, then re-arbitrates round-robin.
- Emits the assembled word with the index of the source lane.
- Sits between the per-lane serial front-ends and the word-level consumer.

Parameters:
- n_lanes, 4, number of serial requesters (at least 2).
- width, 8, bits per parallel word (at least 2).
- timeout_cycles, 16, stall limit in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- serial_valid  input  n_lanes  per-lane bit valid; also acts as that lane's request.
- serial_data  input  n_lanes  per-lane serial bit.
- serial_ready  output  n_lanes  per-lane accept, one-hot or zero.
- parallel_valid  output  1  one-cycle word strobe.
- parallel_data  output  width  assembled word.
- parallel_lane  output  $clog2(n_lanes)  source lane of parallel_data.
- timeout_err  output  1  one-cycle abort strobe; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- All outputs are registered. While rst=0: serial_ready=0, parallel_valid=0, parallel_data=0, parallel_lane=0, timeout_err=0. Internally, state=IDLE, bit counter=0, shift register=0, rr pointer=0.
- IDLE state:
  - If any serial_valid is high, pick the first requesting lane at or after the rr pointer, wrapping modulo n_lanes.
  - Register that lane as grant and move to COLLECT. serial_ready[grant] goes high on the next cycle.
  - If no serial_valid is high, stay in IDLE.
- COLLECT state:
  - serial_ready = one-hot(grant).
  - A bit transfers on a cycle where serial_valid[grant] & serial_ready[grant] are both high. Valid on non-granted lanes is ignored; those lanes must hold their bit.
  - Bits arrive LSB first: the first accepted bit lands in parallel_data[0], the width-th in parallel_data[width-1].
  - Accepted bits shift into the top of the shift register, shifting right. The counter increments per accepted bit.
  - On the edge that accepts the width-th bit:
    - parallel_valid=1 for exactly one cycle, with parallel_data = the full word and parallel_lane = grant.
    - Counter clears to 0.
    - rr pointer = (grant+1) mod n_lanes; wrap from n_lanes-1 to 0.
    - State returns to IDLE, and serial_ready drops on that same edge.
- parallel_data and parallel_lane hold their values until the next word; they are not cleared when parallel_valid falls.
- Latency:
  - Grant: the first request in IDLE causes serial_ready on the next cycle.
  - Word: parallel_valid rises on the cycle after the last bit handshake.
  - Minimum cycles per word: width+1, because of one IDLE arbitration cycle.
- Gaps: serial_valid low during COLLECT stalls the transfer and keeps the grant; there is no timeout without the macro.
- Fairness: with all lanes requesting continuously, grants go 0,1,...,n_lanes-1,0,...
- A lane that drops its request before being granted simply loses the turn; nothing is latched for it.
- Reset mid-word: the partial word is discarded, nothing is output, and the next grant starts from lane 0.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A stall counter in COLLECT counts consecutive cycles with serial_valid[grant]=0 and clears on each accepted bit.
  - When it reaches timeout_cycles:
    - timeout_err=1 for one cycle and parallel_lane = grant.
    - The partial word is dropped and parallel_valid stays 0.
    - rr pointer = grant+1 and state goes to IDLE.
- ARB_TIMEOUT_EN undefined: no stall counter; timeout_err is constant 0 and the timeout_cycles parameter is unused.

Decomposition:
- Package serial_lane_arbiter_pkg holds:
  - the state enum (IDLE, COLLECT);
  - the lane index width function (clog2 helper).
- Sub-module rr_pick does the round-robin pick:
  - combinational, parameter n;
  - inputs req[n] and ptr; outputs gnt_idx and any_req.
- The top module holds the FSM, shift register, counters and output registers.

Test Plan:
- Single lane 2, width=8, bits 1,0,1,1,0,0,1,0 sent back-to-back -> serial_ready[2] high for 8 cycles; parallel_valid once; parallel_data=8'h4D, parallel_lane=2.
- Lanes 0 and 3 both requesting continuously, lane 0 sends all ones and lane 3 all zeros -> words in order (lane0, FF), (lane3, 00), (lane0, FF); each word is 9 cycles apart.
- Lane 1 drops valid for 5 cycles after bit 3 -> grant held; lane 0 is not served meanwhile; word is correct when lane 1 resumes.
- rst asserted asynchronously after 4 of 8 bits -> outputs are 0 immediately; no parallel_valid; after release with lanes 0 and 2 requesting, lane 0 is granted first.
- ARB_TIMEOUT_EN with timeout_cycles=16, granted lane 1 stalls after bit 2 -> timeout_err pulses 16 cycles after the last accepted bit, with parallel_lane=1; lane 2 is granted next; no parallel_valid for lane 1.
- rr wrap with n_lanes=4: grant lane 3, then lanes 0 and 3 both requesting -> lane 0 is granted.
